// File: rtl/if_stage_if.sv
// if_stage_if: groups the hazard-unit controls, redirect targets, instruction
// fetch data and the IF/ID register outputs of the instruction-fetch stage.
// Optional macro IF_PERF_CNT_EN adds the stall_cnt / flush_cnt counters.
interface if_stage_if;
  logic        pc_shouldstall;
  logic [1:0]  if_shouldstall;
  logic [1:0]  final_branch;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  // Upstream side: hazard unit, branch resolution and instruction memory.
  modport master (
    output pc_shouldstall, if_shouldstall, final_branch,
    output branch_target, jump_target, jr_target, inst_in,
    input  pc_out, ifid_pc4, ifid_inst, ifid_valid
`ifdef IF_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  // Fetch stage side.
  modport slave (
    input  pc_shouldstall, if_shouldstall, final_branch,
    input  branch_target, jump_target, jr_target, inst_in,
    output pc_out, ifid_pc4, ifid_inst, ifid_valid
`ifdef IF_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, selects the next PC (sequential, branch, jump, jr), and owns
// the IF/ID pipeline register. A redirect always wins over a PC hold.
// Optional macro IF_PERF_CNT_EN adds wrapping stall/flush event counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  if_stage_if.slave    bus
);

  logic [31:0] pc_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_sel_s;
  logic [31:0] target_aligned_s;
  logic        redirect_s;
  logic [31:0] ifid_pc4_r;
  logic [31:0] ifid_inst_r;
  logic        ifid_valid_r;

  // Next-PC candidates: sequential address and word-aligned redirect target.
  always_comb begin
    pc_plus4_s   = pc_r + 32'd4;
    redirect_s   = (bus.final_branch != 2'b00);
    target_sel_s = pc_plus4_s;
    case (bus.final_branch)
      2'b01:   target_sel_s = bus.branch_target;
      2'b10:   target_sel_s = bus.jump_target;
      2'b11:   target_sel_s = bus.jr_target;
      default: target_sel_s = pc_plus4_s;
    endcase
    // Misaligned targets are silently forced to a word boundary.
    target_aligned_s = target_sel_s & 32'hFFFF_FFFC;
  end

  // PC register: redirect beats hold, hold beats sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_s) begin
      pc_r <= target_aligned_s;
    end else if (bus.pc_shouldstall) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= pc_plus4_s;
    end
  end

  // IF/ID register: advance, hold, or flush to a bubble (pc4 kept on flush).
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_inst_r  <= NOP_INST;
      ifid_valid_r <= 1'b0;
    end else begin
      case (bus.if_shouldstall)
        2'b00: begin
          ifid_pc4_r   <= pc_plus4_s;
          ifid_inst_r  <= bus.inst_in;
          ifid_valid_r <= 1'b1;
        end
        2'b01: begin
          ifid_pc4_r   <= ifid_pc4_r;
          ifid_inst_r  <= ifid_inst_r;
          ifid_valid_r <= ifid_valid_r;
        end
        default: begin
          ifid_pc4_r   <= ifid_pc4_r;
          ifid_inst_r  <= NOP_INST;
          ifid_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_out     = pc_r;
  assign bus.ifid_pc4   = ifid_pc4_r;
  assign bus.ifid_inst  = ifid_inst_r;
  assign bus.ifid_valid = ifid_valid_r;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Event counters: holds (code 01) and flushes (codes 10/11), wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'h0000_0000;
      flush_cnt_r <= 32'h0000_0000;
    end else begin
      if (bus.if_shouldstall == 2'b01) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bus.if_shouldstall[1]) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of ID.
- Holds the PC register, selects the next PC, and drives the instruction-memory address.
- Owns the IF/ID pipeline register.
- Consumes the hazard unit's PC-hold, IF-control and final-branch signals: holds, advances or flushes fetch, and hands {PC+4, instruction, valid} to ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word written into IF/ID on reset or flush (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_shouldstall  in  1  1 = hold PC (from hazard unit)
- if_shouldstall  in  2  IF/ID control: 00 advance, 01 hold, 10 flush, 11 treated as flush
- final_branch  in  2  PC source: 00 PC+4, 01 branch_target, 10 jump_target, 11 jr_target
- branch_target  in  32  resolved branch address
- jump_target  in  32  j/jal address
- jr_target  in  32  jr register value
- inst_in  in  32  instruction-memory read data (combinational, addressed by pc_out)
- pc_out  out  32  current PC / instruction-memory address
- ifid_pc4  out  32  PC+4 of the instruction held in IF/ID
- ifid_inst  out  32  instruction held in IF/ID
- ifid_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high. rst has priority over all inputs.
- Reset values: pc_out = RESET_PC, ifid_pc4 = 0, ifid_inst = NOP_INST, ifid_valid = 0, perf counters = 0.
- pc_plus4 = pc_out + 4, computed modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- PC update, each rising edge when rst = 0:
  - redirect = (final_branch != 00).
  - If redirect: PC loads the selected target, regardless of pc_shouldstall. A redirect always wins over a hold.
  - Else if pc_shouldstall = 1: PC holds.
  - Else: PC <= pc_plus4.
  - Loaded targets have bits [1:0] forced to 00 (word alignment); no exception is raised.
- IF/ID update, each rising edge when rst = 0:
  - 00 advance: ifid_inst <= inst_in, ifid_pc4 <= pc_plus4, ifid_valid <= 1.
  - 01 hold: all IF/ID fields keep their value.
  - 10/11 flush: ifid_inst <= NOP_INST, ifid_valid <= 0; ifid_pc4 keeps its old value.
- Hold with flush-free redirect: redirect with if_shouldstall = 01 moves the PC while IF/ID holds. This is a legal case.
- pc_shouldstall = 1 with if_shouldstall = 00 re-latches the same instruction next cycle. This combination is legal but the hazard unit never generates it.
- Latency: the instruction at PC N appears in IF/ID one edge after pc_out = N, provided that edge is an advance. A redirect issued on edge k produces pc_out = target after edge k; that target's instruction reaches IF/ID after edge k+1.
- Reset mid-stall or mid-flush: rst wins and all state returns to reset values on that edge.
- No combinational path from inputs to any output except pc_out = PC register. All outputs are registered.

Optional Feature:
- Macro IF_PERF_CNT_EN. Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on every non-reset edge with if_shouldstall = 01.
  - flush_cnt increments on every non-reset edge with if_shouldstall[1] = 1.
  - Both wrap at 2^32 and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with RESET_PC = 0 -> pc_out = 0, ifid_valid = 0, ifid_inst = 0; release, inst_in = 32'h2010_0001, controls 00 -> after 1 edge pc_out = 4, ifid_inst = 32'h2010_0001, ifid_pc4 = 4, ifid_valid = 1.
- Load-use stall: pc_shouldstall = 1, if_shouldstall = 01, final_branch = 00 for 2 edges from pc_out = 8 -> pc_out stays 8, IF/ID unchanged; release -> pc_out = 12.
- Taken branch: final_branch = 01, branch_target = 32'h40, if_shouldstall = 10, pc_shouldstall = 0 at pc_out = 16 -> after edge pc_out = 32'h40, ifid_valid = 0, ifid_inst = 0.
- Redirect beats hold: final_branch = 11, jr_target = 32'h0000_0103, pc_shouldstall = 1 -> pc_out = 32'h0000_0100. With if_shouldstall = 01, IF/ID is unchanged.
- Wrap and mid-op reset: force pc_out = 32'hFFFF_FFFC via jump, advance -> pc_out = 0, ifid_pc4 = 0. Assert rst during a stall -> reset values on the next edge.
- Perf counters (IF_PERF_CNT_EN): 3 hold edges + 2 flush edges (one using code 11) -> stall_cnt = 3, flush_cnt = 2.
